// File: rtl/ascon_pack.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package   : ascon_pack                                                     |
// | Purpose   : Shared ASCON types, the round-constant table, the permutation  |
// |             FSM state type and the three per-round layer functions         |
// |             (add_constant, substitution_layer, diffusion_layer).           |
// | Contents  : type_state    - five 64-bit words x0..x4 (index 0 is x0)       |
// |             type_fsm_perm - IDLE / RUN                                     |
// |             round_constant[0:11]                                           |
// | Revision  : 1.0 - initial release                                          |
// +----------------------------------------------------------------------------+
package ascon_pack;

  // Ascending packed range so that {x0, x1, x2, x3, x4} lands with x0 at index 0.
  typedef logic [0:4][63:0] type_state;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } type_fsm_perm;

  localparam logic [63:0] round_constant [0:11] = '{
    64'h00000000000000f0, 64'h00000000000000e1, 64'h00000000000000d2,
    64'h00000000000000c3, 64'h00000000000000b4, 64'h00000000000000a5,
    64'h0000000000000096, 64'h0000000000000087, 64'h0000000000000078,
    64'h0000000000000069, 64'h000000000000005a, 64'h000000000000004b
  };

  function automatic logic [63:0] ror64(input logic [63:0] v, input int unsigned n);
    return (v >> n) | (v << (64 - n));
  endfunction

  // Round constant goes into x2; indices beyond the table leave the state untouched.
  function automatic type_state add_constant(input type_state s, input logic [3:0] r);
    type_state o;
    o = s;
    if (r <= 4'd11) o[2] = s[2] ^ round_constant[r];
    return o;
  endfunction

  // Bit-sliced 5-bit S-box applied to all 64 columns in parallel.
  function automatic type_state substitution_layer(input type_state s);
    logic [63:0] x0, x1, x2, x3, x4;
    logic [63:0] t0, t1, t2, t3, t4;
    x0 = s[0] ^ s[4];
    x1 = s[1];
    x2 = s[2] ^ s[1];
    x3 = s[3];
    x4 = s[4] ^ s[3];
    t0 = ~x0 & x1;
    t1 = ~x1 & x2;
    t2 = ~x2 & x3;
    t3 = ~x3 & x4;
    t4 = ~x4 & x0;
    x0 = x0 ^ t1;
    x1 = x1 ^ t2;
    x2 = x2 ^ t3;
    x3 = x3 ^ t4;
    x4 = x4 ^ t0;
    x1 = x1 ^ x0;
    x0 = x0 ^ x4;
    x3 = x3 ^ x2;
    x2 = ~x2;
    return {x0, x1, x2, x3, x4};
  endfunction

  function automatic type_state diffusion_layer(input type_state s);
    type_state o;
    o[0] = s[0] ^ ror64(s[0], 19) ^ ror64(s[0], 28);
    o[1] = s[1] ^ ror64(s[1], 61) ^ ror64(s[1], 39);
    o[2] = s[2] ^ ror64(s[2],  1) ^ ror64(s[2],  6);
    o[3] = s[3] ^ ror64(s[3], 10) ^ ror64(s[3], 17);
    o[4] = s[4] ^ ror64(s[4],  7) ^ ror64(s[4], 41);
    return o;
  endfunction

endpackage : ascon_pack
`default_nettype wire

// File: rtl/permutation_round.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module    : permutation_round                                              |
// | Purpose   : One combinational ASCON round:                                 |
// |             diffusion(substitution(add_constant(state, round))).           |
// | Ports     : state_i  in  type_state  state entering the round              |
// |             round_i  in  4           round index selecting the constant    |
// |             state_o  out type_state  state leaving the round               |
// | Revision  : 1.0 - initial release                                          |
// +----------------------------------------------------------------------------+
module permutation_round
  import ascon_pack::*;
(
  input  type_state  state_i,
  input  logic [3:0] round_i,
  output type_state  state_o
);

  assign state_o = diffusion_layer(substitution_layer(add_constant(state_i, round_i)));

endmodule : permutation_round
`default_nettype wire

// File: rtl/permutation_iter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module    : permutation_iter                                               |
// | Purpose   : Iterative ASCON permutation, one round per clock (two rounds   |
// |             per clock when PERM_UNROLL2_EN is defined). start/done         |
// |             handshake; round_start_i selects 12, 8 or 6 rounds.            |
// | Macro     : PERM_UNROLL2_EN - chain two rounds per cycle; odd start        |
// |             indices are rejected.                                          |
// | Ports     : clock_i        in  1           rising-edge clock               |
// |             resetb_i       in  1           async active-low reset          |
// |             start_i        in  1           start request (IDLE only)       |
// |             round_start_i  in  4           first round index               |
// |             state_i        in  type_state  state loaded on accepted start  |
// |             state_o        out type_state  permuted state                  |
// |             round_o        out 4           current round index             |
// |             busy_o         out 1           high while running              |
// |             done_o         out 1           one-cycle completion pulse      |
// | Revision  : 1.0 - initial release                                          |
// +----------------------------------------------------------------------------+
module permutation_iter
  import ascon_pack::*;
#(
  parameter int unsigned LAST_ROUND = 11
) (
  input  logic       clock_i,
  input  logic       resetb_i,
  input  logic       start_i,
  input  logic [3:0] round_start_i,
  input  type_state  state_i,
  output type_state  state_o,
  output logic [3:0] round_o,
  output logic       busy_o,
  output logic       done_o
);

  localparam logic [3:0] c_LAST_ROUND = 4'(LAST_ROUND);

  type_fsm_perm r_fsm;
  type_state    r_state;
  logic [3:0]   r_round;
  logic         r_done;

  type_state    w_next;
  logic         w_last;
  logic         w_accept;
  logic [3:0]   w_round_inc;

`ifdef PERM_UNROLL2_EN
  type_state  w_mid;
  logic [3:0] w_round_b;

  assign w_round_b = r_round + 4'd1;

  permutation_round u_round_a (
    .state_i (r_state),
    .round_i (r_round),
    .state_o (w_mid)
  );

  permutation_round u_round_b (
    .state_i (w_mid),
    .round_i (w_round_b),
    .state_o (w_next)
  );

  // The second chained round is the final one.
  assign w_last      = (w_round_b == c_LAST_ROUND);
  assign w_accept    = start_i && (round_start_i <= c_LAST_ROUND) && !round_start_i[0];
  assign w_round_inc = r_round + 4'd2;
`else
  permutation_round u_round (
    .state_i (r_state),
    .round_i (r_round),
    .state_o (w_next)
  );

  assign w_last      = (r_round == c_LAST_ROUND);
  assign w_accept    = start_i && (round_start_i <= c_LAST_ROUND);
  assign w_round_inc = r_round + 4'd1;
`endif

  always_ff @(posedge clock_i or negedge resetb_i) begin
    if (!resetb_i) begin
      r_fsm   <= IDLE;
      r_state <= '0;
      r_round <= '0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_fsm)
        IDLE: begin
          if (w_accept) begin
            r_state <= state_i;
            r_round <= round_start_i;
            r_fsm   <= RUN;
          end
        end
        RUN: begin
          r_state <= w_next;
          if (w_last) begin
            // Park the index on the final round so IDLE reports it consistently.
            r_round <= c_LAST_ROUND;
            r_done  <= 1'b1;
            r_fsm   <= IDLE;
          end else begin
            r_round <= w_round_inc;
          end
        end
        default: r_fsm <= IDLE;
      endcase
    end
  end

  assign state_o = r_state;
  assign round_o = r_round;
  assign busy_o  = (r_fsm == RUN);
  assign done_o  = r_done;

endmodule : permutation_iter
`default_nettype wire
